// File: rtl/regfile_mp_sb_if.sv
// Register-file port bundle: read ports, two write-back ports, issue/flush scoreboard
// controls, collision flag and debug tap. Vectors are packed port-major.
interface regfile_mp_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRP*AW-1:0]   rd_addr;
    logic [NRP*XLEN-1:0] rd_data;
    logic [NRP-1:0]      rd_busy;
    logic [1:0]          wr_en;
    logic [2*AW-1:0]     wr_addr;
    logic [2*XLEN-1:0]   wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                wr_err;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, wr_err, dbg_data
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, wr_err, dbg_data
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a busy-bit
// scoreboard for RAW stalls; x0 reads as zero and is never busy.
module regfile_mp_sb_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]        rd_addr,
    input  logic [1:0]           wr_en,
    input  logic [1:0][AW-1:0]   wr_addr,
    input  logic [1:0][XLEN-1:0] wr_data,
    input  logic [XLEN-1:0]      reg_val,
    input  logic                 busy_bit,
    output logic [XLEN-1:0]      rd_data,
    output logic                 rd_busy
);
    logic hit0, hit1;

    always_comb begin
        hit1    = wr_en[1] && (wr_addr[1] == rd_addr);
        hit0    = wr_en[0] && (wr_addr[0] == rd_addr);
        rd_data = reg_val;
        rd_busy = busy_bit & ~(hit0 | hit1);
        if (rd_addr == '0) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end else if (hit1) begin
            rd_data = wr_data[1];
        end else if (hit0) begin
            rd_data = wr_data[0];
        end
    end
endmodule

module regfile_mp_sb #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int NRP     = 2,
    parameter int DBG_IDX = 31
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_sb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic                      wr_err_q, wr_err_d;

    logic [1:0][AW-1:0]     wa;
    logic [1:0][XLEN-1:0]   wd;
    logic [NRP-1:0][AW-1:0]   ra;
    logic [NRP-1:0][XLEN-1:0] rdd;

    assign wa = bus.wr_addr;
    assign wd = bus.wr_data;
    assign ra = bus.rd_addr;

    always_comb begin
        regs_d   = regs_q;
        busy_d   = busy_q;
        wr_err_d = bus.wr_en[0] & bus.wr_en[1] & (wa[0] == wa[1]) & (wa[0] != '0);
        // Port 1 is applied last so it wins a same-register collision.
        for (int w = 0; w < 2; w++)
            if (bus.wr_en[w] && wa[w] != '0) regs_d[wa[w]] = wd[w];
        for (int r = 1; r < NREG; r++) begin
            if (bus.flush)
                busy_d[r] = 1'b0;
            else if (bus.iss_en && bus.iss_addr == AW'(r))
                busy_d[r] = 1'b1;
            else if ((bus.wr_en[0] && wa[0] == AW'(r)) || (bus.wr_en[1] && wa[1] == AW'(r)))
                busy_d[r] = 1'b0;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q   <= '0;
            busy_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        regfile_mp_sb_rdport #(.XLEN(XLEN), .AW(AW)) u_rd (
            .rd_addr (ra[p]),
            .wr_en   (bus.wr_en),
            .wr_addr (wa),
            .wr_data (wd),
            .reg_val (regs_q[ra[p]]),
            .busy_bit(busy_q[ra[p]]),
            .rd_data (rdd[p]),
            .rd_busy (bus.rd_busy[p])
        );
    end

    assign bus.rd_data  = rdd;
    assign bus.wr_err   = wr_err_q;
    assign bus.dbg_data = regs_q[DBG_IDX];
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed scenarios plus randomized traffic checked every cycle against an
// array-based model of the register file and scoreboard.
module tb_regfile_mp_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   run = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) bus ();
    regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .DBG_IDX(31)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [XLEN-1:0] m_regs [NREG];
    bit   [NREG-1:0] m_busy = '0;
    bit              m_err  = 1'b0;
    initial for (int i = 0; i < NREG; i++) m_regs[i] = '0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa(int w);   return bus.wr_addr[w*AW +: AW];   endfunction
    function automatic logic [XLEN-1:0] wd(int w); return bus.wr_data[w*XLEN +: XLEN]; endfunction
    function automatic logic [XLEN-1:0] rdd(int p); return bus.rd_data[p*XLEN +: XLEN]; endfunction

    // Reference model: apply effects from lowest to highest priority.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_busy = '0;
            m_err  = 1'b0;
        end else begin
            m_err = bus.wr_en[0] && bus.wr_en[1] && wa(0) == wa(1) && wa(0) != 0;
            for (int w = 0; w < 2; w++)
                if (bus.wr_en[w]) begin
                    if (wa(w) != 0) m_regs[wa(w)] = wd(w);
                    m_busy[wa(w)] = 1'b0;
                end
            if (bus.iss_en) m_busy[bus.iss_addr] = 1'b1;
            if (bus.flush) m_busy = '0;
            m_busy[0] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst && run) begin
            for (int p = 0; p < NRP; p++) begin
                logic [AW-1:0]   a;
                logic [XLEN-1:0] ed;
                bit              hit;
                a   = bus.rd_addr[p*AW +: AW];
                hit = (bus.wr_en[1] && wa(1) == a) || (bus.wr_en[0] && wa(0) == a);
                if (a == 0) ed = '0;
                else if (bus.wr_en[1] && wa(1) == a) ed = wd(1);
                else if (bus.wr_en[0] && wa(0) == a) ed = wd(0);
                else ed = m_regs[a];
                chk("cmp_rd_data", rdd(p), ed);
                chk("cmp_rd_busy", 32'(bus.rd_busy[p]), 32'(m_busy[a] && !hit && a != 0));
            end
            chk("cmp_wr_err", 32'(bus.wr_err), 32'(m_err));
            chk("cmp_dbg", bus.dbg_data, m_regs[31]);
        end
    end

    task automatic tick(); @(posedge clk); #1; endtask
    task automatic idle();
        bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
    endtask
    task automatic setwr(int w, bit en, logic [AW-1:0] a, logic [XLEN-1:0] d);
        bus.wr_en[w] = en; bus.wr_addr[w*AW +: AW] = a; bus.wr_data[w*XLEN +: XLEN] = d;
    endtask
    task automatic setrd(int p, logic [AW-1:0] a); bus.rd_addr[p*AW +: AW] = a; endtask

    initial begin
        idle();
        bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run = 1'b1;
        setrd(0, 5); setrd(1, 31);
        #1;
        chk("rst_rd_data", rdd(0), 32'h0);
        chk("rst_rd_busy", 32'(bus.rd_busy), 32'h0);
        chk("rst_dbg", bus.dbg_data, 32'h0);
        chk("rst_wr_err", 32'(bus.wr_err), 32'h0);

        // Bypass priority on a same-register collision
        tick();
        setwr(0, 1, 7, 32'h11); setwr(1, 1, 7, 32'h22); setrd(0, 7); setrd(1, 7);
        #1;
        chk("byp_p0", rdd(0), 32'h22);
        chk("byp_p1", rdd(1), 32'h22);
        tick(); idle();
        #1;
        chk("byp_stored", rdd(0), 32'h22);
        chk("model_x7", m_regs[7], 32'h22);
        chk("byp_err", 32'(bus.wr_err), 32'h1);
        tick();
        chk("err_clear", 32'(bus.wr_err), 32'h0);

        // x0 guard
        setwr(0, 1, 0, 32'hFFFF_FFFF); bus.iss_en = 1; bus.iss_addr = 0; setrd(0, 0); setrd(1, 0);
        #1;
        chk("x0_data", rdd(0), 32'h0);
        chk("x0_busy", 32'(bus.rd_busy), 32'h0);
        tick(); idle();
        #1;
        chk("x0_data_after", rdd(1), 32'h0);
        chk("x0_busy_after", 32'(bus.rd_busy), 32'h0);

        // Scoreboard RAW
        bus.iss_en = 1; bus.iss_addr = 3;
        tick(); idle(); setrd(0, 3);
        for (int c = 0; c < 3; c++) begin
            #1 chk("raw_busy", 32'(bus.rd_busy[0]), 32'h1);
            tick();
        end
        setwr(0, 1, 3, 32'h55);
        #1;
        chk("raw_wb_busy", 32'(bus.rd_busy[0]), 32'h0);
        chk("raw_wb_data", rdd(0), 32'h55);
        tick(); idle();
        #1;
        chk("raw_after_busy", 32'(bus.rd_busy[0]), 32'h0);
        chk("raw_after_data", rdd(0), 32'h55);

        // Simultaneous issue and write-back
        bus.iss_en = 1; bus.iss_addr = 9;
        tick();
        setwr(1, 1, 9, 32'hA); setrd(1, 9);
        tick(); idle();
        #1;
        chk("reiss_data", rdd(1), 32'hA);
        chk("reiss_busy", 32'(bus.rd_busy[1]), 32'h1);

        // Flush against concurrent issue
        setwr(0, 1, 31, 32'h3131_3131);
        tick(); idle();
        bus.iss_en = 1; bus.iss_addr = 2;  tick();
        bus.iss_addr = 4;  tick();
        bus.iss_addr = 31; tick();
        bus.iss_addr = 6; bus.flush = 1; tick(); idle();
        setrd(0, 2); setrd(1, 4); #1;
        chk("fl_x2", 32'(bus.rd_busy[0]), 32'h0);
        chk("fl_x4", 32'(bus.rd_busy[1]), 32'h0);
        setrd(0, 31); setrd(1, 6); #1;
        chk("fl_x31", 32'(bus.rd_busy[0]), 32'h0);
        chk("fl_x6", 32'(bus.rd_busy[1]), 32'h0);
        chk("fl_dbg", bus.dbg_data, 32'h3131_3131);

        // Asynchronous reset mid-operation
        tick();
        setwr(0, 1, 5, 32'h1234_5678); setwr(1, 1, 5, 32'hDEAD_BEEF);
        tick(); idle(); setrd(0, 5);
        #1;
        chk("pre_rst_x5", rdd(0), 32'hDEAD_BEEF);
        chk("pre_rst_err", 32'(bus.wr_err), 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_x5", rdd(0), 32'h0);
        chk("mid_rst_dbg", bus.dbg_data, 32'h0);
        chk("mid_rst_err", 32'(bus.wr_err), 32'h0);
        tick(); tick();
        rst = 1'b0;

        // Randomized traffic; narrow address range to provoke collisions and bypasses
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int w = 0; w < 2; w++)
                setwr(w, $urandom_range(0, 1), AW'($urandom_range(0, n[0] ? 31 : 7)), $urandom);
            for (int p = 0; p < NRP; p++) setrd(p, AW'($urandom_range(0, n[1] ? 31 : 7)));
            bus.iss_en   = $urandom_range(0, 2) != 0;
            bus.iss_addr = AW'($urandom_range(0, n[2] ? 31 : 7));
            bus.flush    = $urandom_range(0, 40) == 0;
        end
        tick(); idle();
        tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
